// File: rtl/debouncer_pkg.sv
// Purpose: shared types for debounce blocks (per-channel FSM state encoding).
// Latency: n/a (types only).
// Backpressure: n/a.
package debouncer_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } db_state_t;

endpackage

// File: rtl/debouncer_bank_if.sv
// Purpose: bundles raw switch inputs and debounced level/event outputs of a bank.
// Latency: n/a (wiring only).
// Backpressure: none; outputs are level and single-cycle pulses, no handshake.
interface debouncer_bank_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] i_sw;
    logic [N_CH-1:0] o_level;
    logic [N_CH-1:0] o_rise;
    logic [N_CH-1:0] o_fall;
    logic [N_CH-1:0] o_long;

    // Switch-side driver (board / bench)
    modport master (
        output i_sw,
        input  o_level, o_rise, o_fall, o_long
    );

    // Debouncer side
    modport slave (
        input  i_sw,
        output o_level, o_rise, o_fall, o_long
    );
endinterface

// File: rtl/debouncer_channel.sv
// Purpose: one switch channel: synchronizer, debounce FSM, long-press hold counter.
// Latency: SYNC_STAGES + DB_TICKS + 1 cycles from a clean input edge to level/pulse.
// Backpressure: none; pulses are one cycle wide and never stalled.
module debouncer_channel
    import debouncer_pkg::*;
#(
    parameter int DB_TICKS    = 2_000_000,
    parameter int LONG_TICKS  = 100_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_long
);
    localparam int CW = $clog2(DB_TICKS);
    localparam int HW = $clog2(LONG_TICKS + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DB_TICKS - 1);
    localparam logic [HW-1:0] HC_MAX   = HW'(LONG_TICKS);
    localparam logic [HW-1:0] HC_FIRE  = HW'(LONG_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    db_state_t              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [HW-1:0]          hc_q, hc_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign s = sync_q[SYNC_STAGES-1];

    // Shift the raw asynchronous input through the synchronizer chain
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], i_sw};
    end

    // Debounce next-state: any opposite sample inside a window aborts it
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ZERO: begin
                if (s) begin
                    state_d = WAIT1;
                    cnt_d   = CNT_LOAD;
                end
            end
            WAIT1: begin
                if (!s)                 state_d = ZERO;
                else if (cnt_q != '0)   cnt_d   = cnt_q - CW'(1);
                else begin
                    state_d = ONE;
                    rise_d  = 1'b1;
                end
            end
            ONE: begin
                if (!s) begin
                    state_d = WAIT0;
                    cnt_d   = CNT_LOAD;
                end
            end
            WAIT0: begin
                if (s)                  state_d = ONE;
                else if (cnt_q != '0)   cnt_d   = cnt_q - CW'(1);
                else begin
                    state_d = ZERO;
                    fall_d  = 1'b1;
                end
            end
            default: state_d = ZERO;
        endcase
    end

    // Hold counter: zero while debounced low, counts (saturating) while debounced high,
    // so a WAIT0->ONE bounce neither restarts it nor re-fires the long pulse
    always_comb begin
        hc_d = hc_q;
        case (state_q)
            ONE, WAIT0: if (hc_q != HC_MAX) hc_d = hc_q + HW'(1);
            default:    hc_d = '0;
        endcase
    end

    // Register FSM state, counters and edge pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ZERO;
            cnt_q   <= '0;
            hc_q    <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hc_q    <= hc_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign o_level = (state_q == ONE) || (state_q == WAIT0);
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;
    // hc passes LONG_TICKS-1 exactly once per press since it saturates above it
    assign o_long  = (hc_q == HC_FIRE);

endmodule

// File: rtl/debouncer_bank.sv
// Purpose: bank of N_CH independent switch debouncers with rise/fall/long-press events.
// Latency: SYNC_STAGES + DB_TICKS + 1 cycles from a clean input edge to level/pulse.
// Backpressure: none; simultaneous events on different channels appear together.
module debouncer_bank #(
    parameter int N_CH        = 4,
    parameter int DB_TICKS    = 2_000_000,
    parameter int LONG_TICKS  = 100_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    debouncer_bank_if.slave   bus
);
    logic [N_CH-1:0] level_w;
    logic [N_CH-1:0] rise_w;
    logic [N_CH-1:0] fall_w;
    logic [N_CH-1:0] long_w;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debouncer_channel #(
            .DB_TICKS    (DB_TICKS),
            .LONG_TICKS  (LONG_TICKS),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_sw    (bus.i_sw[g]),
            .o_level (level_w[g]),
            .o_rise  (rise_w[g]),
            .o_fall  (fall_w[g]),
            .o_long  (long_w[g])
        );
    end

    assign bus.o_level = level_w;
    assign bus.o_rise  = rise_w;
    assign bus.o_fall  = fall_w;
    assign bus.o_long  = long_w;

endmodule

// File: doc/debouncer_bank.md
DEBOUNCER_BANK -- requirements
Module: debouncer_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning number of independent switch channels (>=1).
REQ-002 SHALL have parameter DB_TICKS, default 2_000_000, meaning debounce stability window in clock cycles (>=2).
REQ-003 SHALL have parameter LONG_TICKS, default 100_000_000, meaning long-press threshold in clock cycles, counted from debounced assertion (> DB_TICKS).
REQ-004 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer flop depth per channel (>=2).
REQ-005 i_clk  input  1  sole clock; all state on rising edge.
REQ-006 i_rst_n  input  1  asynchronous, active-low reset.
REQ-007 i_sw  input  N_CH  raw asynchronous switch inputs, one bit per channel.
REQ-008 o_level  output  N_CH  debounced level per channel.
REQ-009 o_rise  output  N_CH  one-cycle pulse on debounced 0->1.
REQ-010 o_fall  output  N_CH  one-cycle pulse on debounced 1->0.
REQ-011 o_long  output  N_CH  one-cycle pulse once per press when held LONG_TICKS.

Function
REQ-012 Each channel SHALL pass i_sw through SYNC_STAGES flops; s = last stage; channels fully independent.
REQ-013 Per-channel FSM SHALL have states ZERO, WAIT1, ONE, WAIT0 and a down-counter cnt of width $clog2(DB_TICKS).
REQ-014 ZERO: s=1 -> WAIT1, cnt<=DB_TICKS-1; else stay.
REQ-015 WAIT1: s=0 -> ZERO (no pulse); s=1 and cnt!=0 -> cnt-1; s=1 and cnt==0 -> ONE.
REQ-016 ONE: s=0 -> WAIT0, cnt<=DB_TICKS-1; else stay.
REQ-017 WAIT0: s=1 -> ONE (no pulse); s=0 and cnt!=0 -> cnt-1; s=0 and cnt==0 -> ZERO.
REQ-018 o_level SHALL be 1 in ONE and WAIT0, 0 in ZERO and WAIT1 (decoded from state register).
REQ-019 o_rise SHALL be registered, high exactly the first cycle in ONE after WAIT1; o_fall high exactly the first cycle in ZERO after WAIT0.
REQ-020 Latency i_sw edge -> o_level change/pulse SHALL be SYNC_STAGES + DB_TICKS + 1 cycles for a clean edge.
REQ-021 Any opposite-level sample during WAIT1/WAIT0 SHALL abort the window; a later edge restarts the full DB_TICKS count.
REQ-022 Hold counter hc, width $clog2(LONG_TICKS+1), SHALL clear to 0 on WAIT1->ONE, increment each cycle in ONE and WAIT0, saturate at LONG_TICKS, clear in ZERO.
REQ-023 o_long SHALL be high for the single cycle hc==LONG_TICKS-1; bounces WAIT0->ONE SHALL not restart hc or re-fire o_long.
REQ-024 o_rise and o_fall SHALL never assert in the same cycle on one channel; simultaneous events on different channels SHALL all be reported in the same cycle.

Reset
REQ-025 i_rst_n low SHALL immediately force all synchronizer flops, cnt, hc to 0, all FSMs to ZERO, all outputs to 0.
REQ-026 Reset mid-window SHALL discard progress; no o_fall/o_rise/o_long SHALL be generated by reset entry or exit.
REQ-027 After reset release with i_sw held high, o_rise SHALL appear at the full REQ-020 latency.

Structure
REQ-028 Package debouncer_pkg SHALL hold the state enum (ZERO, WAIT1, ONE, WAIT0; 2-bit) shared with future debounce blocks.
REQ-029 Per-channel logic SHALL be sub-module debouncer_channel (synchronizer, FSM, counters, pulses), instantiated N_CH times via generate.
REQ-030 Counter widths SHALL derive from parameters via $clog2; no hard-coded widths.

Verification (N_CH=4, DB_TICKS=4, LONG_TICKS=16, SYNC_STAGES=2)
REQ-031 Clean press: i_sw[0] 0->1 at cycle 0, held -> o_level[0]=1 and o_rise[0] pulse at cycle 7 only; other channels stay 0.
REQ-032 Bounce: i_sw[1] high 3 cycles, low 2, high 3, low -> no o_rise[1], o_level[1]=0 throughout.
REQ-033 Release: after REQ-031, i_sw[0] 1->0 at cycle 40 -> o_fall[0] pulse and o_level[0]=0 at cycle 47.
REQ-034 Long press: i_sw[2] held 100 cycles from cycle 0 -> o_rise[2] at 7, o_long[2] single pulse at 22, no further o_long.
REQ-035 Simultaneous: all i_sw 0->1 at cycle 0 -> o_rise=4'b1111 at cycle 7 only.
REQ-036 Reset mid-window: i_sw[3] high at 0, i_rst_n low cycles 5-6 -> all outputs 0 at once; o_rise[3] at cycle 14 (7 after release).
